// File: rtl/bios_load_sink.sv
// bios_load_sink: receives BIOS words from the loader, buffers them and commits them to boot memory.
// Optional BIOS_LOAD_CKSUM_EN adds a running 16-bit sum of committed words (cksum, cksum_ok).
module bios_load_sink #(
    parameter int WORDS = 8192,
    parameter int FIFO_DEPTH = 4,
    parameter int REQ_MARGIN = 2,
    parameter int MEM_AW = 20,
    parameter logic [MEM_AW-1:0] MEM_BASE = 20'hFC000
`ifdef BIOS_LOAD_CKSUM_EN
    ,
    parameter logic [15:0] CKSUM_EXP = 16'h0000
`endif
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    output logic              bios_req,
    input  logic [12:0]       bios_addr,
    input  logic [15:0]       bios_din,
    input  logic              bios_wr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [15:0]       mem_dout,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              seq_err,
    output logic              ovf_err
`ifdef BIOS_LOAD_CKSUM_EN
    ,
    output logic [15:0]       cksum,
    output logic              cksum_ok
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] REQ_LIM = (PW+1)'(FIFO_DEPTH - REQ_MARGIN);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [28:0]   fifo_mem [FIFO_DEPTH];
    logic [28:0]   head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_count, count_nxt;
    logic [CW-1:0] accepted, committed, acc_nxt, com_nxt;
    logic [12:0]   expected;
    logic          wr_try, push, pop, commit, req_nxt;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        head = fifo_mem[rd_ptr];
        commit = mem_we && mem_ready;
        pop = fifo_count != '0 && (!mem_we || mem_ready);
        wr_try = state == LOAD && bios_wr && !start;
        push = wr_try && (fifo_count != DEPTH_C || pop);
        count_nxt = start ? '0 : fifo_count + (PW+1)'(push) - (PW+1)'(pop);
        acc_nxt = start ? '0 : accepted + CW'(push);
        com_nxt = committed + CW'(commit);
        state_nxt = start ? LOAD
                  : (state == LOAD && accepted == WORDS_C) ? DRAIN
                  : (state == DRAIN && fifo_count == '0 && com_nxt == WORDS_C) ? DONE
                  : state;
        req_nxt = state_nxt == LOAD && acc_nxt < WORDS_C - CW'(1) && count_nxt < REQ_LIM;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            accepted <= '0;
            committed <= '0;
            expected <= '0;
            bios_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_dout <= '0;
            seq_err <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            state <= state_nxt;
            bios_req <= req_nxt;
            fifo_count <= count_nxt;
            accepted <= acc_nxt;
            if (start) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                committed <= '0;
                expected <= '0;
                mem_we <= 1'b0;
                seq_err <= 1'b0;
                ovf_err <= 1'b0;
            end else begin
                committed <= com_nxt;
                ovf_err <= ovf_err | (wr_try && !push);
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    expected <= bios_addr + 13'd1;
                    seq_err <= seq_err | (bios_addr != expected);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    mem_we <= 1'b1;
                    mem_addr <= MEM_BASE + MEM_AW'(head[28:16]);
                    mem_dout <= head[15:0];
                end else if (commit) begin
                    mem_we <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr] <= {bios_addr, bios_din};
        end
    end

    assign busy = state == LOAD || state == DRAIN;
    assign done = state == DONE;

`ifdef BIOS_LOAD_CKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset || start) begin
            cksum <= '0;
        end else if (commit) begin
            cksum <= cksum + mem_dout;
        end
    end

    assign cksum_ok = done && cksum == CKSUM_EXP;
`endif
endmodule

// File: tb/tb_bios_load_sink.sv
// tb_bios_load_sink: randomized loader/memory stimulus against a queue-based model of committed words.
module tb_bios_load_sink;
    localparam int WORDS = 8192;
    localparam int FIFO_DEPTH = 4;
    localparam int REQ_MARGIN = 2;
    localparam logic [19:0] MEM_BASE = 20'hFC000;

    logic        clk_sys = 1'b0;
    logic        reset, start, bios_wr, mem_ready;
    logic [12:0] bios_addr;
    logic [15:0] bios_din;
    logic        bios_req, mem_we, busy, done, seq_err, ovf_err;
    logic [19:0] mem_addr;
    logic [15:0] mem_dout;
`ifdef BIOS_LOAD_CKSUM_EN
    logic [15:0] cksum;
    logic        cksum_ok;
`endif

    bios_load_sink #(
        .WORDS(WORDS), .FIFO_DEPTH(FIFO_DEPTH), .REQ_MARGIN(REQ_MARGIN),
        .MEM_AW(20), .MEM_BASE(MEM_BASE)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .start(start), .bios_req(bios_req),
        .bios_addr(bios_addr), .bios_din(bios_din), .bios_wr(bios_wr),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we), .mem_ready(mem_ready),
        .busy(busy), .done(done), .seq_err(seq_err), .ovf_err(ovf_err)
`ifdef BIOS_LOAD_CKSUM_EN
        , .cksum(cksum), .cksum_ok(cksum_ok)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [19:0] a;
        logic [15:0] d;
        int          t;
    } ent_t;

    ent_t        q[$];
    int          checks = 0, errors = 0, cyc = 0, acc = 0, com = 0, sent = 0, data_mode = 0;
    bit          active = 0, seq_e = 0, ovf_e = 0, done_e = 0, prev_req = 0;
    logic [12:0] exp_addr = '0;
    logic [15:0] sum_e = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", tag, got, want, cyc);
            if (errors >= 40) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endtask

    // A written word reaches the port two cycles after its write, or once its predecessor is accepted.
    function automatic bit head_at_port();
        return q.size() > 0 && q[0].t <= cyc - 2;
    endfunction

    function automatic logic [15:0] word_data(input logic [12:0] a);
        return data_mode == 0 ? {3'b0, a} ^ 16'hA5A5 : data_mode == 1 ? 16'($urandom) : 16'h0001;
    endfunction

    task automatic clear_model(input bit act);
        q.delete();
        acc = 0;
        com = 0;
        exp_addr = '0;
        seq_e = 0;
        ovf_e = 0;
        sum_e = '0;
        active = act;
    endtask

    task automatic step();
        int infl;
        bit we_e;
        infl = q.size();
        we_e = head_at_port();
        if (reset) clear_model(0);
        else if (start) clear_model(1);
        else begin
            if (we_e && mem_ready) begin
                sum_e += q[0].d;
                q.delete(0);
                com++;
            end
            if (active && acc < WORDS && bios_wr) begin
                if (infl == FIFO_DEPTH + 1 && !mem_ready) ovf_e = 1;
                else begin
                    if (bios_addr != exp_addr) seq_e = 1;
                    exp_addr = bios_addr + 13'd1;
                    q.push_back('{MEM_BASE + 20'(bios_addr), bios_din, cyc});
                    acc++;
                end
            end
        end
        @(posedge clk_sys);
        #1;
        cyc++;
        we_e = head_at_port();
        done_e = active && acc == WORDS && com == WORDS;
        check("mem_we", 32'(mem_we), 32'(we_e));
        if (we_e) begin
            check("mem_addr", 32'(mem_addr), 32'(q[0].a));
            check("mem_dout", 32'(mem_dout), 32'(q[0].d));
        end
        check("busy", 32'(busy), 32'(active && !done_e));
        check("done", 32'(done), 32'(done_e));
        check("bios_req", 32'(bios_req),
              32'(active && acc < WORDS - 1 && (q.size() - int'(we_e)) < FIFO_DEPTH - REQ_MARGIN));
        check("seq_err", 32'(seq_err), 32'(seq_e));
        check("ovf_err", 32'(ovf_err), 32'(ovf_e));
`ifdef BIOS_LOAD_CKSUM_EN
        check("cksum", 32'(cksum), 32'(sum_e));
        check("cksum_ok", 32'(cksum_ok), 32'(done_e && sum_e == 16'h0000));
`endif
    endtask

    task automatic pulse_start();
        start = 1;
        bios_wr = 0;
        mem_ready = 1;
        step();
        start = 0;
        sent = 0;
        prev_req = 0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        bios_wr = 0;
        step();
        reset = 0;
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_dout", 32'(mem_dout), 32'h0);
    endtask

    // Loader answers a visible bios_req with a write on the following cycle.
    task automatic run(input int stop_at, input int wr_pct, input int rdy_pct,
                       input int stall_at, input int gap_at);
        int budget = 40000;
        int stall_left = 0;
        while (!done_e && sent < stop_at) begin
            if (budget == 0) begin
                check("timeout", 32'h0, 32'h1);
                break;
            end
            budget--;
            if (sent == stall_at && stall_left == 0) begin
                stall_left = 20;
                stall_at = -1;
            end
            mem_ready = stall_left == 0 && int'($urandom_range(99)) < rdy_pct;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) check("stall_req", 32'(bios_req), 32'h0);
            end
            bios_wr = prev_req && sent < WORDS && int'($urandom_range(99)) < wr_pct;
            bios_addr = 13'((gap_at >= 0 && sent >= gap_at) ? sent + 1 : sent);
            bios_din = word_data(bios_addr);
            prev_req = bios_req;
            if (bios_wr) sent++;
            step();
        end
        bios_wr = 0;
    endtask

    initial begin
        reset = 1;
        start = 0;
        bios_wr = 0;
        mem_ready = 0;
        bios_addr = '0;
        bios_din = '0;
        step();
        step();
        reset = 0;
        check("init_addr", 32'(mem_addr), 32'h0);
        data_mode = 0;
        pulse_start();
        run(WORDS + 1, 100, 100, -1, -1);
        check("clean_done", 32'(done), 32'h1);
        bios_wr = 1;
        bios_addr = 13'd5;
        repeat (3) step();
        bios_wr = 0;
        data_mode = 1;
        pulse_start();
        run(WORDS + 1, 80, 60, 3000, -1);
        check("bp_done", 32'(done), 32'h1);
        data_mode = 0;
        pulse_start();
        run(10, 100, 100, -1, 2);
        check("seq_set", 32'(seq_err), 32'h1);
        mem_ready = 1;
        repeat (6) step();
        pulse_reset();
        pulse_start();
        mem_ready = 0;
        for (int i = 0; i < 6; i++) begin
            bios_wr = 1;
            bios_addr = 13'(i);
            bios_din = word_data(bios_addr);
            step();
        end
        bios_wr = 0;
        check("ovf_set", 32'(ovf_err), 32'h1);
        mem_ready = 1;
        repeat (8) step();
        pulse_reset();
        data_mode = 2;
        pulse_start();
        run(100, 90, 90, -1, -1);
        pulse_reset();
        pulse_start();
        run(50, 90, 90, -1, -1);
        pulse_start();
        check("restart_we", 32'(mem_we), 32'h0);
        run(WORDS + 1, 90, 90, -1, -1);
        check("restart_done", 32'(done), 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
